// File: rtl/cfg_write_arbiter_pkg.sv
// Shared constants for the PWM configuration-bank write arbiter: register map and FSM encoding.
package cfg_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

endpackage

// File: rtl/cfg_write_arbiter_if.sv
// Two-requester write handshake (valid/ready + address/data) feeding the config-bank arbiter.
interface cfg_write_arbiter_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/cfg_write_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant; the requester not granted last time wins a tie.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  assign gnt0 = valid0 & (~valid1 | last_grant);
  assign gnt1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/cfg_write_arbiter.sv
// Round-robin arbiter owning the five PWM configuration registers; one write committed per
// two cycles, with a saturating count of writes to unmapped addresses.
module cfg_write_arbiter
  import cfg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cfg_write_arbiter_if.slave   bus,
  output logic [DATA_W-1:0]    en_reg_out_7_0,
  output logic [DATA_W-1:0]    en_reg_out_15_8,
  output logic [DATA_W-1:0]    en_reg_pwm_7_0,
  output logic [DATA_W-1:0]    en_reg_pwm_15_8,
  output logic [DATA_W-1:0]    pwm_duty_cycle,
  output logic                 wr_strobe,
  output logic                 wr_src,
  output logic [ERR_CNT_W-1:0] bad_addr_cnt
);

  state_e            state_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;
  logic              hold_src_q;
  logic              gnt0;
  logic              gnt1;
  logic              accept_ok;

  rr_arb2 u_rr_arb2 (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant_q),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  // Readys are the only combinational outputs; held low while reset is asserted.
  assign accept_ok      = rst_n & (state_q == ST_IDLE);
  assign bus.req0_ready = accept_ok & gnt0;
  assign bus.req1_ready = accept_ok & gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      hold_addr_q     <= '0;
      hold_data_q     <= '0;
      hold_src_q      <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
      wr_strobe       <= 1'b0;
      wr_src          <= 1'b0;
      bad_addr_cnt    <= '0;
    end else begin
      wr_strobe <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            hold_addr_q <= gnt1 ? bus.req1_addr : bus.req0_addr;
            hold_data_q <= gnt1 ? bus.req1_data : bus.req0_data;
            hold_src_q  <= gnt1;
            state_q     <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          case (hold_addr_q)
            ADDR_EN_OUT_LO: en_reg_out_7_0  <= hold_data_q;
            ADDR_EN_OUT_HI: en_reg_out_15_8 <= hold_data_q;
            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= hold_data_q;
            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= hold_data_q;
            ADDR_PWM_DUTY:  pwm_duty_cycle  <= hold_data_q;
            default: begin
              if (bad_addr_cnt != '1) bad_addr_cnt <= bad_addr_cnt + ERR_CNT_W'(1);
            end
          endcase
          wr_strobe    <= 1'b1;
          wr_src       <= hold_src_q;
          last_grant_q <= hold_src_q;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Randomized bench for cfg_write_arbiter against a transaction-level model of the register bank.
module tb_cfg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe, wr_src;
  logic [7:0] bad_addr_cnt;

  always #5 clk = ~clk;

  cfg_write_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus_if ();

  cfg_write_arbiter #(.ADDR_W(7), .DATA_W(8), .ERR_CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus_if),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .wr_strobe       (wr_strobe),
    .wr_src          (wr_src),
    .bad_addr_cnt    (bad_addr_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model: register file, error count, pending transaction in flight, last committed source.
  int unsigned m_reg[5];
  int unsigned m_bad, m_last, m_addr, m_data, m_src, m_src_out;
  bit          m_busy, m_strobe;
  bit          acc0, acc1;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned dut_reg(input int i);
    case (i)
      0:       return en_reg_out_7_0;
      1:       return en_reg_out_15_8;
      2:       return en_reg_pwm_7_0;
      3:       return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic model_reset();
    foreach (m_reg[i]) m_reg[i] = 0;
    m_bad = 0; m_last = 1; m_busy = 0; m_strobe = 0; m_src_out = 0;
    acc0 = 0; acc1 = 0;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 5; i++) check_eq($sformatf("reg%0d", i), dut_reg(i), m_reg[i]);
    check_eq("bad_addr_cnt", bad_addr_cnt, m_bad);
    check_eq("wr_strobe", wr_strobe, m_strobe);
    if (m_strobe) check_eq("wr_src", wr_src, m_src_out);
  endtask

  task automatic drive(input int k, input bit v, input int unsigned a, input int unsigned d);
    if (k == 0) begin
      bus_if.req0_valid = v; bus_if.req0_addr = 7'(a); bus_if.req0_data = 8'(d);
    end else begin
      bus_if.req1_valid = v; bus_if.req1_addr = 7'(a); bus_if.req1_data = 8'(d);
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    bit v0, v1, e0, e1;
    int unsigned a0, a1, d0, d1;
    @(negedge clk);
    v0 = bus_if.req0_valid; v1 = bus_if.req1_valid;
    a0 = bus_if.req0_addr;  a1 = bus_if.req1_addr;
    d0 = bus_if.req0_data;  d1 = bus_if.req1_data;
    e0 = !m_busy && v0 && (!v1 || m_last == 1);
    e1 = !m_busy && v1 && (!v0 || m_last == 0);
    check_eq("req0_ready", bus_if.req0_ready, e0);
    check_eq("req1_ready", bus_if.req1_ready, e1);
    check_outputs();
    @(posedge clk);
    m_strobe = 0;
    if (m_busy) begin
      if (m_addr < 5) m_reg[m_addr] = m_data;
      else if (m_bad < 255) m_bad++;
      m_strobe = 1; m_src_out = m_src; m_last = m_src; m_busy = 0;
    end else if (e0) begin
      m_busy = 1; m_addr = a0; m_data = d0; m_src = 0;
    end else if (e1) begin
      m_busy = 1; m_addr = a1; m_data = d1; m_src = 1;
    end
    acc0 = e0; acc1 = e1;
    #1;
  endtask

  function automatic int unsigned rand_addr();
    return ($urandom_range(0, 4) == 0) ? $urandom_range(5, 127) : $urandom_range(0, 4);
  endfunction

  // Legal requester behaviour: hold until accepted, occasionally drop, else issue something new.
  task automatic rand_drive();
    if (bus_if.req0_valid && !acc0) begin
      if ($urandom_range(0, 9) == 0) bus_if.req0_valid = 1'b0;
    end else drive(0, $urandom_range(0, 2) != 0, rand_addr(), $urandom_range(0, 255));
    if (bus_if.req1_valid && !acc1) begin
      if ($urandom_range(0, 9) == 0) bus_if.req1_valid = 1'b0;
    end else drive(1, $urandom_range(0, 2) != 0, rand_addr(), $urandom_range(0, 255));
  endtask

  // Assert reset away from clock edges; release just after a rising edge.
  task automatic apply_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_req0_ready", bus_if.req0_ready, 0);
    check_eq("rst_req1_ready", bus_if.req1_ready, 0);
    check_outputs();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cycle();

    // Saturated tie after a mid-run reset: req0 first, then strict alternation.
    drive(0, 1'b1, 7'h00, 8'hAA);
    drive(1, 1'b1, 7'h01, 8'h55);
    apply_reset();
    repeat (10) cycle();
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b0, 0, 0);
    repeat (3) cycle();
    check_eq("out_lo_aa", en_reg_out_7_0, 8'hAA);
    check_eq("out_hi_55", en_reg_out_15_8, 8'h55);

    // Single write to duty cycle.
    drive(0, 1'b1, 7'h04, 8'h80);
    cycle();
    if (acc0) drive(0, 1'b0, 0, 0);
    repeat (3) cycle();
    check_eq("duty_80", pwm_duty_cycle, 8'h80);

    // Both requesters hit the same register; last commit wins.
    apply_reset();
    drive(0, 1'b1, 7'h02, 8'h0F);
    drive(1, 1'b1, 7'h02, 8'hF0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (acc0) drive(0, 1'b0, 0, 0);
      if (acc1) drive(1, 1'b0, 0, 0);
    end
    repeat (2) cycle();
    check_eq("pwm_lo_f0", en_reg_pwm_7_0, 8'hF0);

    for (int i = 0; i < 400; i++) begin
      cycle();
      rand_drive();
    end

    // Flood of unmapped writes saturates the error counter.
    drive(0, 1'b0, 0, 0);
    drive(1, 1'b1, 7'h05, 8'hFF);
    apply_reset();
    for (int i = 0; i < 640; i++) begin
      cycle();
      if (acc1) drive(1, 1'b1, $urandom_range(5, 127), $urandom_range(0, 255));
    end
    check_eq("bad_sat", bad_addr_cnt, 8'hFF);

    // Reset landing in COMMIT abandons the write.
    drive(1, 1'b0, 0, 0);
    apply_reset();
    drive(1, 1'b1, 7'h03, 8'h3C);
    cycle();
    check_eq("abandon_accept", acc1, 1);
    rst_n = 1'b0;
    drive(1, 1'b0, 0, 0);
    model_reset();
    #1;
    check_eq("abandon_pwm_hi", en_reg_pwm_15_8, 0);
    check_eq("abandon_strobe", wr_strobe, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cycle();
    check_eq("abandon_pwm_hi_after", en_reg_pwm_15_8, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
